// File: rtl/fifo_sync_fwft_if.sv
// fifo_sync_fwft_if -- handshake bundle for fifo_sync_fwft.
//   master : producer/consumer side (drives flush, wr_data, we, re)
//   slave  : the FIFO itself (drives full, ovf, rd_data, ne, ae, level, unf)
interface fifo_sync_fwft_if #(
  parameter int ADDRWIDTH = 5,
  parameter int DATAWIDTH = 18
);
  logic                 flush;
  logic [DATAWIDTH-1:0] wr_data;
  logic                 we;
  logic                 full;
  logic                 ovf;
  logic [DATAWIDTH-1:0] rd_data;
  logic                 re;
  logic                 ne;
  logic                 ae;
  logic [ADDRWIDTH:0]   level;
  logic                 unf;

  modport master (
    output flush, wr_data, we, re,
    input  full, ovf, rd_data, ne, ae, level, unf
  );

  modport slave (
    input  flush, wr_data, we, re,
    output full, ovf, rd_data, ne, ae, level, unf
  );
endinterface

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft -- single-clock show-ahead FIFO.
//   DEPTH = 2**ADDRWIDTH word RAM (registered read) -> mid register -> head
//   register driving rd_data. level counts every word held anywhere.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; overrides flush/we/re
//   bus    : fifo_sync_fwft_if.slave
//            flush/we/wr_data/re in; rd_data/ne (show-ahead head), level,
//            full (level >= DEPTH-SLOP), ae (level <= AE_LEVEL), sticky ovf/unf out
// Build option: define FIFO_SYNC_FWFT_ERR_HALT_EN to print an instance-named
//   message and end simulation when ovf or unf would be set.
module fifo_sync_fwft #(
  parameter int ADDRWIDTH = 5,
  parameter int DATAWIDTH = 18,
  parameter int SLOP      = 4,
  parameter int AE_LEVEL  = 2
) (
  input  logic clk,
  input  logic reset,
  fifo_sync_fwft_if.slave bus
);
  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] LVL_MAX = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] FULL_TH = (ADDRWIDTH+1)'(DEPTH - SLOP);
  localparam logic [ADDRWIDTH:0] AE_TH   = (ADDRWIDTH+1)'(AE_LEVEL);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [ADDRWIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDRWIDTH:0]   level_q, level_nxt, ram_cnt;
  logic [DATAWIDTH-1:0] head_q, mid_q;
  logic                 head_vld, mid_vld;
  logic                 full_q, ae_q, ovf_q, unf_q;

  logic pop, wr_acc, head_take, mid_free, rd_en, byp, ram_we;
  logic ovf_set, unf_set;

  always_comb begin
    pop       = bus.re & head_vld;
    // At level==DEPTH a write only fits if the head leaves the same edge.
    wr_acc    = bus.we & ((level_q != LVL_MAX) | pop);
    head_take = (pop | ~head_vld) & mid_vld;
    mid_free  = ~mid_vld | head_take;
    ram_cnt   = level_q - (ADDRWIDTH+1)'(head_vld) - (ADDRWIDTH+1)'(mid_vld);
    rd_en     = (ram_cnt != '0) & mid_free;
    // A word arriving behind a non-empty FIFO with nothing queued in RAM
    // skips the RAM and lands in mid, so a pop on the next edge still finds
    // it (no bubble). Writes into an empty FIFO keep the two-edge RAM path.
    byp       = wr_acc & (ram_cnt == '0) & mid_free & (level_q != '0);
    ram_we    = wr_acc & ~byp;
    level_nxt = level_q + (ADDRWIDTH+1)'(wr_acc) - (ADDRWIDTH+1)'(pop);
    ovf_set   = bus.we & ~wr_acc;
    unf_set   = bus.re & ~head_vld;
  end

  always_ff @(posedge clk) begin
    if (ram_we && !reset && !bus.flush) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      head_vld <= 1'b0;
      mid_vld  <= 1'b0;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      head_vld <= 1'b0;
      mid_vld  <= 1'b0;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        mid_q  <= mem[rd_ptr];
      end else if (byp) begin
        mid_q  <= bus.wr_data;
      end
      mid_vld  <= rd_en | byp | (mid_vld & ~head_take);
      if (head_take) head_q <= mid_q;
      head_vld <= head_take | (head_vld & ~pop);
      level_q  <= level_nxt;
      full_q   <= (level_nxt >= FULL_TH);
      ae_q     <= (level_nxt <= AE_TH);
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

`ifdef FIFO_SYNC_FWFT_ERR_HALT_EN
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush && (ovf_set || unf_set)) begin
      $display("%m: %s error, halting", ovf_set ? "overflow" : "underflow");
      $finish;
    end
  end
`else
  // Errors only raise the sticky ovf/unf flags; the FIFO keeps running.
`endif

  assign bus.rd_data = head_q;
  assign bus.ne      = head_vld;
  assign bus.level   = level_q;
  assign bus.full    = full_q;
  assign bus.ae      = ae_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
endmodule

// File: doc/fifo_sync_fwft.md
FIFO_SYNC_FWFT -- requirements
Module: fifo_sync_fwft

Interface
REQ-001 Parameter ADDRWIDTH, default 5: FIFO holds DEPTH = 2^ADDRWIDTH words.
REQ-002 Parameter DATAWIDTH, default 18: word width.
REQ-003 Parameter SLOP, default 4: full asserts when level >= DEPTH-SLOP.
REQ-004 Parameter AE_LEVEL, default 2: ae asserts when level <= AE_LEVEL.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  synchronous empty command; data discarded.
REQ-009 wr_data  input  DATAWIDTH  write data.
REQ-010 we  input  1  write enable.
REQ-011 full  output  1  almost full, registered.
REQ-012 ovf  output  1  sticky overflow error.
REQ-013 rd_data  output  DATAWIDTH  head word, valid while ne=1 (show-ahead).
REQ-014 re  input  1  pop head word.
REQ-015 ne  output  1  not empty; rd_data valid.
REQ-016 ae  output  1  almost empty, registered.
REQ-017 level  output  ADDRWIDTH+1  words accepted and not yet popped.
REQ-018 unf  output  1  sticky underflow error.

Function
REQ-019 Storage SHALL be a DEPTH-word dual-port RAM with registered read, plus a head register feeding rd_data; total capacity is DEPTH words.
REQ-020 Show-ahead: head word SHALL appear on rd_data with ne=1 without re.
REQ-021 Write into empty FIFO at edge N SHALL yield ne=1 and rd_data=word after edge N+2.
REQ-022 re with ne=1 pops head; the next word SHALL be on rd_data after the same edge if >=2 words are stored (no bubble on sustained reads).
REQ-023 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH with no wrap.
REQ-024 level: +1 on accepted write without pop, -1 on pop without accepted write, unchanged if both or neither.
REQ-025 we while level==DEPTH and re=0: write dropped, state unchanged, ovf set.
REQ-026 we and re both high at level==DEPTH with ne=1: both accepted, level stays DEPTH.
REQ-027 re while ne=0: pop ignored, state unchanged, unf set.
REQ-028 we and re both high at level==0: write accepted, re treated as underflow.
REQ-029 full and ae SHALL be computed from next-cycle level and registered (no extra latency vs level).
REQ-030 Data order SHALL be strictly preserved; no word duplicated or lost except by flush or REQ-025.
REQ-031 flush SHALL, at the next edge, zero pointers and level, clear ne/full, set ae; we/re in a flush cycle ignored; ovf/unf not cleared.

Reset
REQ-032 While reset=1 at an edge: level=0, ne=0, full=0, ae=1, ovf=0, unf=0, pointers=0; rd_data is don't-care.
REQ-033 reset SHALL override flush, we and re; reset mid-stream discards all data.

Configuration
REQ-034 Macro FIFO_SYNC_FWFT_ERR_HALT_EN: when defined, setting ovf or unf SHALL also print an instance-named message and end simulation; when undefined, only the sticky flags are set and the FIFO continues per REQ-025/027.

Verification
REQ-035 Defaults; write 0x00001 at edge 0 into empty FIFO -> ne=1, rd_data=0x00001, level=1 after edge 2.
REQ-036 Write 32 words 0..31 back-to-back, then re held 32 cycles -> rd_data 0..31 in order, one per cycle, ne=0 after last pop, full=1 from level 28.
REQ-037 Level 32, we=1 re=0 -> ovf=1, level stays 32; then we=1 re=1 -> accepted, level 32, order intact.
REQ-038 Level 0, re=1 -> unf=1, ne=0, level 0 (macro undefined); with FIFO_SYNC_FWFT_ERR_HALT_EN defined -> simulation ends.
REQ-039 Level 10, flush=1 with we=1 -> next cycle level=0, ne=0, ae=1, ovf/unf unchanged.
REQ-040 Random we/re, 10000 cycles, reset pulsed mid-run -> scoreboard match, level equals model, ae/full match thresholds every cycle.
